// File: rtl/serial_slave_port.sv
// Responder for one slave lane of the serial bus: deserialises request frames,
// commits writes to a local register file and serialises the acknowledge/read response.
module serial_slave_port #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx,
    output logic              tx,
    input  logic              busy,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RW        = 3'd1,
        ADDR      = 3'd2,
        DATA      = 3'd3,
        RSP_START = 3'd4,
        RSP_ACK   = 3'd5,
        RSP_DATA  = 3'd6
    } state_t;

    state_t              state_r;
    logic                rw_r;
    logic                ack_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic [DATA_W-1:0]   txsh_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic [ADDR_W-1:0]   addr_full_s;
    logic [DATA_W-1:0]   data_full_s;
    logic                addr_last_s;
    logic                data_last_s;

    // Field values including the bit on rx now, so the commit edge sees the complete field
    always_comb begin
        addr_full_s = (addr_r >> 1) | (ADDR_W'(rx) << (ADDR_W - 1));
        data_full_s = (data_r >> 1) | (DATA_W'(rx) << (DATA_W - 1));
        addr_last_s = (cnt_r == CNT_W'(ADDR_W - 1));
        data_last_s = (cnt_r == CNT_W'(DATA_W - 1));
    end

    // Frame FSM, register file and registered tx/wdata/wvalid
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
            tx      <= 1'b1;
            wdata   <= '0;
            wvalid  <= 1'b0;
            rw_r    <= 1'b0;
            ack_r   <= 1'b0;
            cnt_r   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            txsh_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            wvalid <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx <= 1'b1;
                    if (!rx) begin
                        state_r <= RW;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RW: begin
                    rw_r    <= rx;
                    cnt_r   <= '0;
                    state_r <= ADDR;
                end
                ADDR: begin
                    addr_r <= addr_full_s;
                    if (addr_last_s) begin
                        cnt_r <= '0;
                        if (rw_r) begin
                            state_r <= DATA;
                        end else begin
                            // read commit: busy decides ACK and whether data is fetched
                            state_r <= RSP_START;
                            tx      <= 1'b0;
                            ack_r   <= ~busy;
                            if (!busy) begin
                                txsh_r <= mem_r[addr_full_s];
                            end else begin
                                txsh_r <= txsh_r;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    data_r <= data_full_s;
                    if (data_last_s) begin
                        cnt_r   <= '0;
                        state_r <= RSP_START;
                        tx      <= 1'b0;
                        ack_r   <= ~busy;
                        if (!busy) begin
                            mem_r[addr_r] <= data_full_s;
                            wdata         <= data_full_s;
                            wvalid        <= 1'b1;
                        end else begin
                            wvalid <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RSP_START: begin
                    tx      <= ack_r;
                    state_r <= RSP_ACK;
                end
                RSP_ACK: begin
                    if (ack_r && !rw_r) begin
                        tx      <= txsh_r[0];
                        txsh_r  <= txsh_r >> 1;
                        cnt_r   <= '0;
                        state_r <= RSP_DATA;
                    end else begin
                        tx      <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                RSP_DATA: begin
                    // bit 0 already left in RSP_ACK; the last count returns the line to idle
                    if (data_last_s) begin
                        tx      <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= IDLE;
                    end else begin
                        tx     <= txsh_r[0];
                        txsh_r <= txsh_r >> 1;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: the driver queues expected responses and
// write pulses, a negedge monitor decodes tx/wvalid and compares them in order.
module tb_serial_slave_port;

    typedef struct {
        logic       ack;
        logic       has_data;
        logic [7:0] data;
        int         start_cyc;
    } rsp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic       clk;
    logic       rstn;
    logic       rx;
    logic       tx;
    logic       busy;
    logic [7:0] wdata;
    logic       wvalid;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    rsp_t rq[$];
    wr_t  wq[$];
    logic [7:0] exp_mem [16];

    rsp_t       cur;
    bit         in_frame = 1'b0;
    int         ph;
    int         bidx;
    logic [7:0] got;

    serial_slave_port #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .rx     (rx),
        .tx     (tx),
        .busy   (busy),
        .wdata  (wdata),
        .wvalid (wvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    endtask

    // One complete frame followed by the minimum response window before the next start bit
    task automatic send_frame(input logic w, input logic [3:0] a, input logic [7:0] d,
                              input logic bsy, input logic noise);
        rsp_t r;
        wr_t  wr;
        int   t0;
        int   window;
        busy = bsy;
        send_bit(1'b0);
        t0 = cyc;
        r.ack       = ~bsy;
        r.has_data  = ~w & ~bsy;
        r.data      = w ? 8'h00 : exp_mem[a];
        r.start_cyc = t0 + (w ? 13 : 5);
        rq.push_back(r);
        if (w && !bsy) begin
            wr.data = d;
            wr.cyc  = t0 + 13;
            wq.push_back(wr);
            exp_mem[a] = d;
        end
        send_bit(w);
        for (int i = 0; i < 4; i++) send_bit(a[i]);
        if (w) begin
            for (int i = 0; i < 8; i++) send_bit(d[i]);
        end
        window = (!w && !bsy) ? 10 : 2;
        for (int i = 0; i < window; i++) send_bit(noise ? logic'(i[0]) : 1'b1);
        rx   = 1'b1;
        busy = 1'b0;
    endtask

    // Monitor: decodes response frames on tx and write pulses on wvalid
    initial begin
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                in_frame = 1'b0;
            end else begin
                if (wvalid !== 1'b0) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wvalid_unexpected actual=%b wdata=%0h expected=0", wvalid, wdata);
                    end else begin
                        wr_t e;
                        e = wq.pop_front();
                        check("wdata", wdata, e.data);
                        check("wvalid_cyc", cyc, e.cyc);
                    end
                end
                if (!in_frame) begin
                    if (tx !== 1'b1) begin
                        if (rq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rsp_unexpected actual_tx=%b expected_tx=1", tx);
                        end else begin
                            cur = rq.pop_front();
                            check("rsp_start_cyc", cyc, cur.start_cyc);
                            check("rsp_start_bit", tx, 0);
                            in_frame = 1'b1;
                            ph = 1;
                        end
                    end
                end else begin
                    case (ph)
                        1: begin
                            check("rsp_ack", tx, cur.ack);
                            bidx = 0;
                            ph = cur.has_data ? 2 : 3;
                        end
                        2: begin
                            got[bidx] = tx;
                            bidx++;
                            if (bidx == 8) begin
                                check("rsp_data", got, cur.data);
                                ph = 3;
                            end
                        end
                        default: begin
                            check("rsp_stop", tx, 1);
                            in_frame = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        rx   = 1'b1;
        busy = 1'b0;
        rstn = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("reset_tx", tx, 1);
        check("reset_wvalid", wvalid, 0);
        check("reset_wdata", wdata, 8'h00);

        send_frame(1'b0, 4'h7, 8'h00, 1'b0, 1'b0);
        send_frame(1'b1, 4'h3, 8'hA5, 1'b0, 1'b0);
        send_frame(1'b0, 4'h3, 8'h00, 1'b0, 1'b1);
        send_frame(1'b1, 4'h3, 8'h5A, 1'b1, 1'b1);
        check("wdata_hold_on_nack", wdata, 8'hA5);
        send_frame(1'b0, 4'h3, 8'h00, 1'b1, 1'b0);
        send_frame(1'b0, 4'h3, 8'h00, 1'b0, 1'b0);

        // reset in the middle of the data field of a write to 0xF
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx   = 1'b1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_model();
        check("midwrite_reset_tx", tx, 1);
        check("midwrite_reset_wvalid", wvalid, 0);
        check("midwrite_reset_wdata", wdata, 8'h00);
        send_frame(1'b0, 4'hF, 8'h00, 1'b0, 1'b0);

        // reset while read data of 0x2 is being shifted out
        send_frame(1'b1, 4'h2, 8'h3C, 1'b0, 1'b0);
        begin
            rsp_t r;
            int   t0;
            send_bit(1'b0);
            t0 = cyc;
            r.ack = 1'b1;
            r.has_data = 1'b1;
            r.data = exp_mem[2];
            r.start_cyc = t0 + 5;
            rq.push_back(r);
            send_bit(1'b0);
            send_bit(1'b0);
            send_bit(1'b1);
            send_bit(1'b0);
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(1'b1);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_model();
        check("rspdata_reset_tx", tx, 1);
        send_frame(1'b0, 4'h2, 8'h00, 1'b0, 1'b0);

        send_frame(1'b1, 4'h1, 8'h11, 1'b0, 1'b1);
        send_frame(1'b0, 4'h1, 8'h00, 1'b0, 1'b1);
        send_frame(1'b1, 4'hF, 8'hFF, 1'b0, 1'b0);
        send_frame(1'b0, 4'hF, 8'h00, 1'b0, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check("rsp_queue_drained", rq.size(), 0);
        check("wr_queue_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
